// File: rtl/regfile_wb_pipe.sv
// Register file / decode stage with a registered write-back stage, read-after-write
// bypass and a load-wait handshake that holds write-back until memory data is valid.
module regfile_wb_pipe #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned SP_INDEX   = 29,
   parameter logic [31:0] SP_RESET   = 32'h0000_7FFC,
   parameter int unsigned LINK_INDEX = 31,
   parameter bit          BYPASS_EN  = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       instruction,
   input  logic              reg_write,
   input  logic              reg_dst,
   input  logic              jal,
   input  logic              mem_to_reg,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] link_addr,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   output logic [DATA_W-1:0] sign_extend,
   output logic              wb_busy,
   output logic              wb_pending
);

   localparam int unsigned       NUM_REGS = 2**ADDR_W;
   localparam logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_RESET);
   localparam logic [5:0]        OP_SLTIU = 6'h0B;
   localparam logic [5:0]        OP_ANDI  = 6'h0C;
   localparam logic [5:0]        OP_ORI   = 6'h0D;
   localparam logic [5:0]        OP_XORI  = 6'h0E;

   typedef enum logic [1:0] {IDLE, STAGED, WAIT_MEM} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   stage_addr_q, stage_addr_d;
   logic [DATA_W-1:0]   stage_data_q, stage_data_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   logic [5:0]          opcode;
   logic [15:0]         imm;
   logic [ADDR_W-1:0]   rs_idx, rt_idx, rd_idx, wb_dest;
   logic [DATA_W-1:0]   wb_wdata;
   logic                is_load, accept;

   assign opcode = instruction[31:26];
   assign imm    = instruction[15:0];
   assign rs_idx = ADDR_W'(instruction[25:21]);
   assign rt_idx = ADDR_W'(instruction[20:16]);
   assign rd_idx = ADDR_W'(instruction[15:11]);

   always_comb begin
      wb_dest  = reg_dst ? rd_idx : rt_idx;
      wb_wdata = mem_to_reg ? mem_data : alu_result;
      if (jal) begin
         wb_dest  = ADDR_W'(LINK_INDEX);
         wb_wdata = link_addr;
      end
   end

   assign is_load    = mem_to_reg && !jal;
   assign wb_busy    = (state_q == WAIT_MEM);
   assign wb_pending = (state_q != IDLE);
   assign accept     = !wb_busy && reg_write && (wb_dest != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         stage_addr_q <= '0;
         stage_data_q <= '0;
      end else begin
         state_q      <= state_d;
         stage_addr_q <= stage_addr_d;
         stage_data_q <= stage_data_d;
      end
   end

   // A staged write commits on the same edge that may capture the next request.
   always_comb begin
      state_d      = state_q;
      stage_addr_d = stage_addr_q;
      stage_data_d = stage_data_q;
      unique case (state_q)
         WAIT_MEM: begin
            if (mem_valid) begin
               stage_data_d = mem_data;
               state_d      = STAGED;
            end
         end
         default: begin
            state_d = IDLE;
            if (accept) begin
               stage_addr_d = wb_dest;
               stage_data_d = wb_wdata;
               state_d      = (is_load && !mem_valid) ? WAIT_MEM : STAGED;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            regs_q[i] <= (i == SP_INDEX) ? SP_INIT : '0;
      end else if (state_q == STAGED) begin
         regs_q[stage_addr_q] <= stage_data_q;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
      logic [DATA_W-1:0] val;
      val = regs_q[idx];
      if (BYPASS_EN && (state_q == STAGED) && (idx == stage_addr_q))
         val = stage_data_q;
      if (idx == '0)
         val = '0;
      return val;
   endfunction

   always_comb begin
      read_data_1 = read_port(rs_idx);
      read_data_2 = read_port(rt_idx);
   end

   always_comb begin
      sign_extend = DATA_W'($signed(imm));
      if ((opcode == OP_SLTIU) || (opcode == OP_ANDI) ||
          (opcode == OP_ORI)   || (opcode == OP_XORI))
         sign_extend = DATA_W'(imm);
   end

endmodule

// File: tb/tb_regfile_wb_pipe.sv
// Bench for regfile_wb_pipe: a bypassing and a non-bypassing instance share one
// stimulus stream and are checked against a reference register model.
module tb_regfile_wb_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic        reg_write, reg_dst, jal, mem_to_reg, mem_valid;
   logic [31:0] alu_result, mem_data, link_addr;
   logic [31:0] rd1_a, rd2_a, se_a, rd1_b, rd2_b, se_b;
   logic        busy_a, pend_a, busy_b, pend_b;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   logic [31:0] model [32];

   typedef struct {
      logic        jal;
      logic        mem_to_reg;
      logic        reg_dst;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] link;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] exp;
   } imm_t;

   vec_t vecs [6];
   imm_t imms [6];
   exp_t sb [$];

   regfile_wb_pipe #(.BYPASS_EN(1'b1)) u_dut (
      .clock(clock), .reset(reset), .instruction(instruction), .reg_write(reg_write),
      .reg_dst(reg_dst), .jal(jal), .mem_to_reg(mem_to_reg), .alu_result(alu_result),
      .mem_data(mem_data), .mem_valid(mem_valid), .link_addr(link_addr),
      .read_data_1(rd1_a), .read_data_2(rd2_a), .sign_extend(se_a),
      .wb_busy(busy_a), .wb_pending(pend_a)
   );

   regfile_wb_pipe #(.BYPASS_EN(1'b0)) u_dut_nb (
      .clock(clock), .reset(reset), .instruction(instruction), .reg_write(reg_write),
      .reg_dst(reg_dst), .jal(jal), .mem_to_reg(mem_to_reg), .alu_result(alu_result),
      .mem_data(mem_data), .mem_valid(mem_valid), .link_addr(link_addr),
      .read_data_1(rd1_b), .read_data_2(rd2_b), .sign_extend(se_b),
      .wb_busy(busy_b), .wb_pending(pend_b)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic idle_inputs();
      reg_write = 1'b0; reg_dst = 1'b0; jal = 1'b0; mem_to_reg = 1'b0; mem_valid = 1'b0;
      alu_result = '0; mem_data = '0; link_addr = '0; instruction = '0;
   endtask

   task automatic read_regs(input logic [4:0] rs, input logic [4:0] rt);
      instruction = {6'h00, rs, rt, 16'h0000};
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = '0;
      model[29] = 32'h0000_7FFC;
   endtask

   task automatic write_req(input logic [4:0] rt, input logic [31:0] data);
      idle_inputs();
      reg_write   = 1'b1;
      alu_result  = data;
      instruction = {6'h00, 5'd0, rt, 16'h0000};
   endtask

   initial begin
      exp_t e;
      vec_t v;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd5,  5'd0,  32'h0000_1234, 32'h0,          32'h0,          5'd5,  32'h0000_1234};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd3,  5'd10, 32'hCAFE_F00D, 32'h0,          32'h0,          5'd10, 32'hCAFE_F00D};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd7,  5'd0,  32'h0000_1111, 32'h5555_AAAA,  32'h0,          5'd7,  32'h5555_AAAA};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 5'd4,  5'd0,  32'h0000_2222, 32'h0000_3333,  32'h0040_0010,  5'd31, 32'h0040_0010};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0,          32'h0,          5'd0,  32'h0000_0000};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd2,  5'd29, 32'h0000_1000, 32'h0,          32'h0,          5'd29, 32'h0000_1000};

      imms[0] = '{6'h0D, 32'h0000_8001};
      imms[1] = '{6'h08, 32'hFFFF_8001};
      imms[2] = '{6'h0B, 32'h0000_8001};
      imms[3] = '{6'h0C, 32'h0000_8001};
      imms[4] = '{6'h0E, 32'h0000_8001};
      imms[5] = '{6'h0F, 32'hFFFF_8001};

      idle_inputs();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      model_reset();
      read_regs(5'd29, 5'd0);
      #1;
      check("reset_sp", rd1_a, 32'h0000_7FFC);
      check("reset_r0", rd2_a, 32'h0);
      check("reset_busy", {31'b0, busy_a}, 32'h0);
      check("reset_pending", {31'b0, pend_a}, 32'h0);

      foreach (vecs[i]) begin
         v = vecs[i];
         idle_inputs();
         reg_write   = 1'b1;
         reg_dst     = v.reg_dst;
         jal         = v.jal;
         mem_to_reg  = v.mem_to_reg;
         mem_valid   = 1'b1;
         alu_result  = v.alu;
         mem_data    = v.mem;
         link_addr   = v.link;
         instruction = {6'h00, 5'd0, v.rt, v.rd, 11'h000};
         sb.push_back('{v.exp_addr, v.exp_data});
         cycle();
         e = sb.pop_front();
         idle_inputs();
         read_regs(e.addr, 5'd0);
         #1;
         check("vec_bypass", rd1_a, e.data);
         check("vec_nobypass_old", rd1_b, model[e.addr]);
         check("vec_pending", {31'b0, pend_a}, {31'b0, e.addr != 5'd0});
         cycle();
         check("vec_array", rd1_a, e.data);
         check("vec_array_nb", rd1_b, e.data);
         if (e.addr != 5'd0) model[e.addr] = e.data;
      end

      // back-to-back writes: first commits while second is staged
      write_req(5'd11, 32'hAAAA_0011);
      cycle();
      write_req(5'd12, 32'hBBBB_0012);
      cycle();
      idle_inputs();
      read_regs(5'd11, 5'd12);
      #1;
      check("b2b_first", rd1_a, 32'hAAAA_0011);
      check("b2b_second_bypass", rd2_a, 32'hBBBB_0012);
      check("b2b_first_nb", rd1_b, 32'hAAAA_0011);
      check("b2b_second_nb_old", rd2_b, model[12]);
      cycle();
      check("b2b_second_nb", rd2_b, 32'hBBBB_0012);
      model[11] = 32'hAAAA_0011;
      model[12] = 32'hBBBB_0012;

      // load stalls write-back for three cycles; concurrent write is ignored
      idle_inputs();
      reg_write   = 1'b1;
      mem_to_reg  = 1'b1;
      mem_data    = 32'h0BAD_0BAD;
      instruction = {6'h00, 5'd0, 5'd8, 16'h0000};
      cycle();
      for (int k = 0; k < 3; k++) begin
         write_req(5'd9, 32'h9999_9999);
         mem_data = 32'h0BAD_0BAD;
         #1;
         check("load_busy", {31'b0, busy_a}, 32'h1);
         check("load_pending", {31'b0, pend_a}, 32'h1);
         cycle();
      end
      idle_inputs();
      mem_valid = 1'b1;
      mem_data  = 32'hDEAD_BEEF;
      #1;
      check("load_busy_last", {31'b0, busy_b}, 32'h1);
      cycle();
      idle_inputs();
      read_regs(5'd8, 5'd9);
      #1;
      check("load_busy_clear", {31'b0, busy_a}, 32'h0);
      check("load_staged_pending", {31'b0, pend_a}, 32'h1);
      check("load_bypass", rd1_a, 32'hDEAD_BEEF);
      check("load_r9_untouched", rd2_a, model[9]);
      cycle();
      check("load_array", rd1_b, 32'hDEAD_BEEF);
      check("load_r9_array", rd2_b, model[9]);
      check("load_idle", {31'b0, pend_a}, 32'h0);
      model[8] = 32'hDEAD_BEEF;

      foreach (imms[i]) begin
         idle_inputs();
         instruction = {imms[i].op, 10'h000, 16'h8001};
         #1;
         check("imm_ext", se_a, imms[i].exp);
      end

      // reset while waiting on a load discards it
      idle_inputs();
      reg_write   = 1'b1;
      mem_to_reg  = 1'b1;
      instruction = {6'h00, 5'd0, 5'd14, 16'h0000};
      cycle();
      idle_inputs();
      #1;
      check("rst_wait_busy_before", {31'b0, busy_a}, 32'h1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_wait_busy", {31'b0, busy_a}, 32'h0);
      check("rst_wait_pending", {31'b0, pend_a}, 32'h0);
      mem_valid = 1'b1;
      mem_data  = 32'h7777_7777;
      cycle();
      idle_inputs();
      read_regs(5'd14, 5'd29);
      #1;
      check("rst_wait_no_stage", {31'b0, pend_a}, 32'h0);
      check("rst_wait_r14", rd1_a, model[14]);
      check("rst_wait_sp", rd2_a, model[29]);
      cycle();
      check("rst_wait_r14_array", rd1_b, model[14]);
      read_regs(5'd5, 5'd8);
      #1;
      check("rst_cleared_r5", rd1_a, model[5]);
      check("rst_cleared_r8", rd2_b, model[8]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_wb_pipe.md
Name: regfile_wb_pipe

Overview:
Parametrised successor to the single-cycle CPU register file/decode stage. Holds the general-purpose register array, two combinational read ports and immediate extension. Adds a registered write-back stage with read-after-write bypass and a load-wait handshake, so slow memory/IO loads stall write-back instead of committing stale data. Sits between the control unit and the ALU, fed by instruction fetch and the memory/IO mux.

Parameters:
DATA_W, 32, register and datapath width (>= 16)
ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
SP_INDEX, 29, index of the stack pointer register
SP_RESET, 32'h0000_7FFC, reset value of the SP register (truncated/zero-extended to DATA_W)
LINK_INDEX, 31, destination register for jal
BYPASS_EN, 1, 1 = staged write forwarded to read ports; 0 = no forwarding

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high
instruction  in  32  current instruction; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], opcode=[31:26]
reg_write  in  1  write-back request this cycle
reg_dst  in  1  1 = destination rd, 0 = destination rt
jal  in  1  link write; destination LINK_INDEX, data link_addr
mem_to_reg  in  1  1 = write data from mem_data, 0 = from alu_result
alu_result  in  DATA_W  ALU result
mem_data  in  DATA_W  memory/IO read data
mem_valid  in  1  mem_data valid this cycle
link_addr  in  DATA_W  PC+4 for jal
read_data_1  out  DATA_W  operand from rs
read_data_2  out  DATA_W  operand from rt
sign_extend  out  DATA_W  extended immediate
wb_busy  out  1  write-back stage cannot accept a request; upstream must hold
wb_pending  out  1  staged write exists (STAGED or WAIT_MEM)

Behaviour:
- Reset: all registers 0 except reg[SP_INDEX]=SP_RESET; state IDLE; stage cleared; wb_busy=0, wb_pending=0. Reset mid-WAIT_MEM discards the pending load.
- Destination: jal -> LINK_INDEX; else reg_dst ? rd : rt. Data: jal -> link_addr; else mem_to_reg ? mem_data : alu_result. jal has priority over mem_to_reg.
- Requests to register 0 are dropped at capture (no state change). reg[0] always reads 0.
- States: IDLE (no staged write), STAGED (addr/data valid, commit next edge), WAIT_MEM (load captured, data not yet valid).
- Accept when wb_busy=0 and reg_write=1 and dest!=0:
  - load (mem_to_reg & !jal) with mem_valid=0 -> WAIT_MEM, latch addr.
  - otherwise -> STAGED, latch addr+data.
- STAGED: commit to array on next edge; simultaneously accept a new request (back-to-back, one write per cycle). No new request -> IDLE.
- WAIT_MEM: wb_busy=1; incoming requests ignored. First cycle with mem_valid=1: latch mem_data, go STAGED.
- Latency: request at edge N -> visible in array after edge N+1; via bypass, visible on read ports during cycle N+1.
- wb_pending=1 in STAGED and WAIT_MEM. wb_busy=1 only in WAIT_MEM (combinational from state).
- Reads combinational. If BYPASS_EN and state==STAGED and read index==staged addr (nonzero) -> staged data, else array. No bypass from WAIT_MEM: consumer must stall on wb_busy.
- Extension: opcode 0x0B sltiu, 0x0C andi, 0x0D ori, 0x0E xori -> zero-extend imm; all others sign-extend imm[15] to DATA_W.

Test Plan:
- Reset then read rs=29, rt=0 -> read_data_1=32'h0000_7FFC, read_data_2=0; wb_busy=0, wb_pending=0.
- addi-style write rt=5, alu_result=32'h1234, reg_dst=0 -> next cycle read rs=5 gives 32'h1234 via bypass (BYPASS_EN=1); after further edge, from array with BYPASS_EN=0.
- Load to $8 with mem_valid low 3 cycles -> wb_busy=1 for 3 cycles, a concurrent write to $9 is ignored; mem_data=32'hDEAD_BEEF with mem_valid -> $8=32'hDEADBEEF, $9 unchanged.
- jal with link_addr=32'h0040_0010 and mem_to_reg=1 -> $31=32'h00400010; write to $0 -> $0 still reads 0.
- Immediate 16'h8001: opcode 0x0D -> sign_extend=32'h0000_8001; opcode 0x08 -> 32'hFFFF_8001.
- Reset asserted during WAIT_MEM -> next cycle state IDLE, wb_busy=0, later mem_valid commits nothing.
